// File: rtl/uart_pkg.sv
// Shared encodings for the UART receive path: one-hot FSM states, parity modes
// and the 3-sample majority helper.
package uart_pkg;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_PARITY = 5'b01000,
    ST_STOP   = 5'b10000
  } rx_state_t;

  localparam logic [1:0] PAR_NONE  = 2'd0;
  localparam logic [1:0] PAR_EVEN  = 2'd1;
  localparam logic [1:0] PAR_ODD   = 2'd2;
  localparam logic [1:0] PAR_NONE3 = 2'd3;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word fall-through FIFO with fill level, sticky overrun and flush.
module uart_sync_fifo #(
  parameter int DEPTH   = 64,
  parameter int WIDTH   = 10,
  parameter int LEVEL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_i,
  input  logic               rd_i,
  input  logic               clr_i,
  input  logic [WIDTH-1:0]   wdata_i,
  output logic [WIDTH-1:0]   rdata_o,
  output logic               empty_o,
  output logic               full_o,
  output logic               over_o,
  output logic [LEVEL_W-1:0] level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             over_q, over_d;
  logic             do_wr, do_rd;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign over_o  = over_q;
  assign level_o = LEVEL_W'(cnt_q);
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

  always_comb begin
    do_rd  = rd_i && !empty_o;
    // A full FIFO still accepts a write when a pop frees a slot in the same clk.
    do_wr  = wr_i && (!full_o || do_rd);
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    over_d = over_q;
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      over_d = 1'b0;
    end else begin
      if (do_wr) wptr_d = wptr_q + AW'(1);
      if (do_rd) rptr_d = rptr_q + AW'(1);
      if (do_wr && !do_rd)      cnt_d = cnt_q + (AW+1)'(1);
      else if (do_rd && !do_wr) cnt_d = cnt_q - (AW+1)'(1);
      if (wr_i && !do_wr) over_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      over_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      over_q <= over_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clr_i && do_wr) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: line synchroniser, oversampled receive FSM with
// majority vote, idle-timeout frame-end pulse and an error-tagged receive FIFO.
//
// state     | meaning
// ST_IDLE   | waiting for a 1->0 transition on sampled line
// ST_START  | start bit, mid-bit vote rejects false starts
// ST_DATA   | DATA_BITS payload bits, voted at mid-bit
// ST_PARITY | parity bit (even/odd modes only)
// ST_STOP   | one or two stop bits, exit at mid-point of the last
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int LEVEL_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 p_Enable_i,
  input  logic                 AcqSig_i,
  input  logic                 Rx_i,
  input  logic [1:0]           ParityMode_i,
  input  logic                 p_TwoStop_i,
  input  logic                 p_BigEnd_i,
  input  logic [15:0]          RxTimeOutSet_i,
  input  logic                 n_Rd_i,
  input  logic                 n_Clr_i,
  output logic [DATA_BITS-1:0] Data_o,
  output logic                 p_ParityErr_o,
  output logic                 p_FrameErr_o,
  output logic                 p_Empty_o,
  output logic                 p_Full_o,
  output logic                 p_Over_o,
  output logic [LEVEL_W-1:0]   RxFifoLevel_o,
  output logic                 p_FrameEnd_o
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int WW = DATA_BITS + 2;
  localparam logic [CW-1:0] TK_LO   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] TK_MID  = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] TK_HI   = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] TK_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  rx_state_t            state_q, state_d;
  logic                 rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  logic [CW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]           vote_q, vote_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d, frm_err_q, frm_err_d;
  logic                 stop2_q, stop2_d;
  logic                 wr_q, wr_d;
  logic [WW-1:0]        word_q, word_d;
  logic                 to_arm_q, to_arm_d;
  logic [CW-1:0]        to_tick_q, to_tick_d;
  logic [15:0]          to_bits_q, to_bits_d;
  logic                 frame_end_q, frame_end_d;
  logic                 bit_now, has_par, start_edge;
  logic [WW-1:0]        fifo_rdata;

  always_comb begin
    state_d     = state_q;
    rx_s1_d     = Rx_i;
    rx_s2_d     = rx_s1_q;
    rx_prev_d   = rx_prev_q;
    tick_d      = tick_q;
    bit_cnt_d   = bit_cnt_q;
    vote_d      = vote_q;
    shift_d     = shift_q;
    par_err_d   = par_err_q;
    frm_err_d   = frm_err_q;
    stop2_d     = stop2_q;
    wr_d        = 1'b0;
    word_d      = word_q;
    to_arm_d    = to_arm_q;
    to_tick_d   = to_tick_q;
    to_bits_d   = to_bits_q;
    frame_end_d = 1'b0;

    bit_now    = maj3({vote_q, rx_s2_q});
    has_par    = (ParityMode_i == PAR_EVEN) || (ParityMode_i == PAR_ODD);
    start_edge = p_Enable_i && AcqSig_i && (state_q == ST_IDLE) && rx_prev_q && !rx_s2_q;

    if (AcqSig_i) rx_prev_d = rx_s2_q;

    if (!p_Enable_i) begin
      state_d = ST_IDLE;
      tick_d  = '0;
    end else if (AcqSig_i) begin
      tick_d = (tick_q == TK_LAST) ? '0 : tick_q + CW'(1);
      if (tick_q == TK_LO)  vote_d[0] = rx_s2_q;
      if (tick_q == TK_MID) vote_d[1] = rx_s2_q;
      case (state_q)
        ST_IDLE: begin
          tick_d = '0;
          if (start_edge) begin
            // The edge tick itself is tick 0 of the start bit.
            state_d   = ST_START;
            tick_d    = CW'(1);
            par_err_d = 1'b0;
            frm_err_d = 1'b0;
          end
        end
        ST_START: begin
          if (tick_q == TK_HI && bit_now) begin
            state_d = ST_IDLE;
            tick_d  = '0;
          end else if (tick_q == TK_LAST) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          if (tick_q == TK_HI) begin
            if (p_BigEnd_i) shift_d = {shift_q[DATA_BITS-2:0], bit_now};
            else            shift_d = {bit_now, shift_q[DATA_BITS-1:1]};
          end
          if (tick_q == TK_LAST) begin
            if (bit_cnt_q == BIT_LAST) begin
              state_d = has_par ? ST_PARITY : ST_STOP;
              stop2_d = 1'b0;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end
        end
        ST_PARITY: begin
          if (tick_q == TK_HI)
            par_err_d = bit_now != ((^shift_q) ^ (ParityMode_i == PAR_ODD));
          if (tick_q == TK_LAST) begin
            state_d = ST_STOP;
            stop2_d = 1'b0;
          end
        end
        ST_STOP: begin
          if (tick_q == TK_HI) begin
            if (!bit_now) frm_err_d = 1'b1;
            if (!p_TwoStop_i || stop2_q) begin
              state_d = ST_IDLE;
              tick_d  = '0;
              wr_d    = 1'b1;
              word_d  = {frm_err_q | !bit_now, par_err_q, shift_q};
            end
          end else if (tick_q == TK_LAST) begin
            stop2_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          tick_d  = '0;
        end
      endcase
    end

    // Idle timeout: armed by each stored character, disarmed after its single pulse.
    if (wr_q) begin
      to_arm_d  = 1'b1;
      to_tick_d = '0;
      to_bits_d = '0;
    end else if (start_edge) begin
      to_tick_d = '0;
      to_bits_d = '0;
    end else if (to_arm_q && AcqSig_i && p_Enable_i && state_q == ST_IDLE &&
                 RxTimeOutSet_i != 16'd0) begin
      if (to_tick_q == TK_LAST) begin
        to_tick_d = '0;
        to_bits_d = to_bits_q + 16'd1;
        if (to_bits_q + 16'd1 == RxTimeOutSet_i) begin
          frame_end_d = 1'b1;
          to_arm_d    = 1'b0;
        end
      end else begin
        to_tick_d = to_tick_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      tick_q      <= '0;
      bit_cnt_q   <= '0;
      vote_q      <= '0;
      shift_q     <= '0;
      par_err_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      stop2_q     <= 1'b0;
      wr_q        <= 1'b0;
      word_q      <= '0;
      to_arm_q    <= 1'b0;
      to_tick_q   <= '0;
      to_bits_q   <= '0;
      frame_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_s1_q     <= rx_s1_d;
      rx_s2_q     <= rx_s2_d;
      rx_prev_q   <= rx_prev_d;
      tick_q      <= tick_d;
      bit_cnt_q   <= bit_cnt_d;
      vote_q      <= vote_d;
      shift_q     <= shift_d;
      par_err_q   <= par_err_d;
      frm_err_q   <= frm_err_d;
      stop2_q     <= stop2_d;
      wr_q        <= wr_d;
      word_q      <= word_d;
      to_arm_q    <= to_arm_d;
      to_tick_q   <= to_tick_d;
      to_bits_q   <= to_bits_d;
      frame_end_q <= frame_end_d;
    end
  end

  uart_sync_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .WIDTH  (WW),
    .LEVEL_W(LEVEL_W)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_i   (wr_q),
    .rd_i   (!n_Rd_i),
    .clr_i  (!n_Clr_i),
    .wdata_i(word_q),
    .rdata_o(fifo_rdata),
    .empty_o(p_Empty_o),
    .full_o (p_Full_o),
    .over_o (p_Over_o),
    .level_o(RxFifoLevel_o)
  );

  assign {p_FrameErr_o, p_ParityErr_o, Data_o} = fifo_rdata;
  assign p_FrameEnd_o = frame_end_q;

endmodule
